// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - execute handshake, write-back outputs and data-memory bus of the Y86 memory stage
interface mem_access_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  icode;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic [31:0] valE;
   logic [31:0] valA;
   logic [31:0] valP;
   logic        out_valid;
   logic [3:0]  icode_out;
   logic [3:0]  rA_out;
   logic [3:0]  rB_out;
   logic [31:0] valE_out;
   logic [31:0] valM_out;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [1:0]  stat;

   modport master (
      output in_valid, icode, rA, rB, valE, valA, valP, mem_ack, mem_rdata,
      input  in_ready, out_valid, icode_out, rA_out, rB_out, valE_out, valM_out,
             mem_req, mem_we, mem_addr, mem_wdata, stat
   );

   modport slave (
      input  in_valid, icode, rA, rB, valE, valA, valP, mem_ack, mem_rdata,
      output in_ready, out_valid, icode_out, rA_out, rB_out, valE_out, valM_out,
             mem_req, mem_we, mem_addr, mem_wdata, stat
   );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - Y86 memory stage; define MEM_ALIGN_CHECK_EN to fault unaligned accesses
module mem_access_stage #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter logic [31:0] ADDR_LIMIT  = 32'h0000_FFFF
) (
   input logic               clock,
   input logic               reset_n,
   mem_access_stage_if.slave bus
);
   localparam logic [3:0] ICODE_NOP  = 4'h1;
   localparam logic [3:0] ICODE_HALT = 4'h0;
   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, HALTED} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [3:0]  icode_q;
   logic [3:0]  ra_q;
   logic [3:0]  rb_q;
   logic [31:0] vale_q;

   logic        dec_access;
   logic        dec_we;
   logic        dec_invalid;
   logic        dec_fault;
   logic [31:0] dec_addr;
   logic [31:0] dec_wdata;

   always_comb begin
      dec_access  = 1'b0;
      dec_we      = 1'b0;
      dec_invalid = 1'b0;
      dec_addr    = bus.valE;
      dec_wdata   = bus.valA;
      case (bus.icode)
         4'h4, 4'hA: begin dec_access = 1'b1; dec_we = 1'b1; end
         4'h8:       begin dec_access = 1'b1; dec_we = 1'b1; dec_wdata = bus.valP; end
         4'h5:       dec_access = 1'b1;
         4'h9, 4'hB: begin dec_access = 1'b1; dec_addr = bus.valA; end
         4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7: dec_access = 1'b0;
         default:    dec_invalid = 1'b1;
      endcase
      // The whole 4-byte word must lie at or below ADDR_LIMIT.
      dec_fault = dec_access && (dec_addr > (ADDR_LIMIT - 32'd3));
`ifdef MEM_ALIGN_CHECK_EN
      if (dec_access && (dec_addr[1:0] != 2'b00))
         dec_fault = 1'b1;
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.icode_out <= ICODE_NOP;
         bus.rA_out    <= 4'hF;
         bus.rB_out    <= 4'hF;
         bus.valE_out  <= 32'd0;
         bus.valM_out  <= 32'd0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'd0;
         bus.mem_wdata <= 32'd0;
         bus.stat      <= STAT_AOK;
         wait_cnt      <= 8'd0;
         icode_q       <= ICODE_NOP;
         ra_q          <= 4'hF;
         rb_q          <= 4'hF;
         vale_q        <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  bus.in_ready <= 1'b0;
                  icode_q      <= bus.icode;
                  ra_q         <= bus.rA;
                  rb_q         <= bus.rB;
                  vale_q       <= bus.valE;
                  if (dec_access && !dec_invalid && !dec_fault) begin
                     state         <= ACCESS;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= dec_we;
                     bus.mem_addr  <= dec_addr;
                     bus.mem_wdata <= dec_wdata;
                     wait_cnt      <= 8'd0;
                  end else begin
                     // Faulting instructions reach write-back as nop so nothing is written.
                     state         <= RESP;
                     bus.out_valid <= 1'b1;
                     bus.rA_out    <= bus.rA;
                     bus.rB_out    <= bus.rB;
                     bus.valE_out  <= bus.valE;
                     bus.valM_out  <= 32'd0;
                     if (dec_invalid) begin
                        bus.icode_out <= ICODE_NOP;
                        bus.stat      <= STAT_INS;
                     end else if (dec_fault) begin
                        bus.icode_out <= ICODE_NOP;
                        bus.stat      <= STAT_ADR;
                     end else begin
                        bus.icode_out <= bus.icode;
                        if (bus.icode == ICODE_HALT)
                           bus.stat <= STAT_HLT;
                     end
                  end
               end
            end
            ACCESS: begin
               if (bus.mem_ack) begin
                  state         <= RESP;
                  bus.mem_req   <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.icode_out <= icode_q;
                  bus.rA_out    <= ra_q;
                  bus.rB_out    <= rb_q;
                  bus.valE_out  <= vale_q;
                  bus.valM_out  <= bus.mem_we ? 32'd0 : bus.mem_rdata;
               end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
                  state         <= RESP;
                  bus.mem_req   <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.icode_out <= ICODE_NOP;
                  bus.rA_out    <= ra_q;
                  bus.rB_out    <= rb_q;
                  bus.valE_out  <= vale_q;
                  bus.valM_out  <= 32'd0;
                  bus.stat      <= STAT_ADR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               bus.out_valid <= 1'b0;
               bus.icode_out <= ICODE_NOP;
               if (bus.stat == STAT_AOK) begin
                  state        <= IDLE;
                  bus.in_ready <= 1'b1;
               end else begin
                  state <= HALTED;
               end
            end
            HALTED: begin
               bus.in_ready  <= 1'b0;
               bus.out_valid <= 1'b0;
               bus.mem_req   <= 1'b0;
               bus.icode_out <= ICODE_NOP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench for the Y86 memory stage
module tb_mem_access_stage;
   logic clock;
   logic reset_n;
   int   checks;
   int   errors;
   int   n;

   mem_access_stage_if bus ();

   mem_access_stage dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic offer(input logic [3:0] ic, input logic [31:0] ve, input logic [31:0] va,
                        input logic [31:0] vp);
      chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.icode    = ic;
      bus.rA       = 4'h2;
      bus.rB       = 4'h3;
      bus.valE     = ve;
      bus.valA     = va;
      bus.valP     = vp;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.in_valid  = 1'b0;
      bus.icode     = 4'h1;
      bus.rA        = 4'hF;
      bus.rB        = 4'hF;
      bus.valE      = 32'd0;
      bus.valA      = 32'd0;
      bus.valP      = 32'd0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
      do_reset();

      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_icode_out", 32'(bus.icode_out), 32'h1);
      chk("rst_rA_out", 32'(bus.rA_out), 32'hF);
      chk("rst_rB_out", 32'(bus.rB_out), 32'hF);
      chk("rst_valE_out", bus.valE_out, 32'd0);
      chk("rst_valM_out", bus.valM_out, 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_stat", 32'(bus.stat), 32'd0);

      // no-access instruction
      offer(4'h6, 32'd5, 32'd7, 32'd9);
      chk("alu_out_valid", 32'(bus.out_valid), 32'd1);
      chk("alu_icode_out", 32'(bus.icode_out), 32'h6);
      chk("alu_rA_out", 32'(bus.rA_out), 32'h2);
      chk("alu_valE_out", bus.valE_out, 32'd5);
      chk("alu_valM_out", bus.valM_out, 32'd0);
      chk("alu_mem_req", 32'(bus.mem_req), 32'd0);
      chk("alu_stat", 32'(bus.stat), 32'd0);
      tick();
      chk("alu_pulse_end", 32'(bus.out_valid), 32'd0);
      chk("alu_icode_nop", 32'(bus.icode_out), 32'h1);
      chk("alu_mem_req_after", 32'(bus.mem_req), 32'd0);

      // mrmovl with three request cycles before ack
      offer(4'h5, 32'h100, 32'h999, 32'd0);
      chk("mr_mem_req", 32'(bus.mem_req), 32'd1);
      chk("mr_mem_we", 32'(bus.mem_we), 32'd0);
      chk("mr_mem_addr", bus.mem_addr, 32'h100);
      tick();
      tick();
      chk("mr_wait_req", 32'(bus.mem_req), 32'd1);
      chk("mr_wait_out_valid", 32'(bus.out_valid), 32'd0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEADBEEF;
      tick();
      bus.mem_ack   = 1'b0;
      chk("mr_out_valid", 32'(bus.out_valid), 32'd1);
      chk("mr_valM_out", bus.valM_out, 32'hDEADBEEF);
      chk("mr_icode_out", 32'(bus.icode_out), 32'h5);
      chk("mr_req_dropped", 32'(bus.mem_req), 32'd0);
      chk("mr_stat", 32'(bus.stat), 32'd0);
      tick();
      chk("mr_ready_again", 32'(bus.in_ready), 32'd1);
      chk("mr_valM_hold", bus.valM_out, 32'hDEADBEEF);

      // pushl with immediate ack
      offer(4'hA, 32'h1FC, 32'h42, 32'h77);
      chk("push_mem_we", 32'(bus.mem_we), 32'd1);
      chk("push_mem_addr", bus.mem_addr, 32'h1FC);
      chk("push_mem_wdata", bus.mem_wdata, 32'h42);
      chk("push_not_yet", 32'(bus.out_valid), 32'd0);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("push_out_valid", 32'(bus.out_valid), 32'd1);
      chk("push_icode_out", 32'(bus.icode_out), 32'hA);
      chk("push_valE_out", bus.valE_out, 32'h1FC);
      chk("push_valM_out", bus.valM_out, 32'd0);
      tick();

      // call writes valP; highest legal word address
      offer(4'h8, 32'hFFFC, 32'h11, 32'h55);
      chk("call_mem_req", 32'(bus.mem_req), 32'd1);
      chk("call_mem_addr", bus.mem_addr, 32'hFFFC);
      chk("call_mem_wdata", bus.mem_wdata, 32'h55);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("call_stat", 32'(bus.stat), 32'd0);
      tick();

      // reset in the middle of an access
      offer(4'hB, 32'h0, 32'h40, 32'h0);
      chk("pop_mem_addr", bus.mem_addr, 32'h40);
      reset_n = 1'b0;
      #1;
      chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
      tick();
      reset_n = 1'b1;

      // out-of-range rmmovl
      offer(4'h4, 32'hFFFE, 32'h1, 32'h0);
      chk("adr_mem_req", 32'(bus.mem_req), 32'd0);
      chk("adr_out_valid", 32'(bus.out_valid), 32'd1);
      chk("adr_stat", 32'(bus.stat), 32'd2);
      chk("adr_icode_nop", 32'(bus.icode_out), 32'h1);
      tick();
      tick();
      chk("adr_halted_ready", 32'(bus.in_ready), 32'd0);
      chk("adr_halted_stat", 32'(bus.stat), 32'd2);
      reset_n = 1'b0;
      #1;
      chk("adr_rst_stat", 32'(bus.stat), 32'd0);
      chk("adr_rst_ready", 32'(bus.in_ready), 32'd1);
      tick();
      reset_n = 1'b1;

      // ret with no ack: request times out
      offer(4'h9, 32'h999, 32'h20, 32'h0);
      chk("to_mem_addr", bus.mem_addr, 32'h20);
      n = 0;
      while (bus.mem_req && n < 300) begin
         n++;
         tick();
      end
      chk("to_req_cycles", 32'(n), 32'd255);
      chk("to_stat", 32'(bus.stat), 32'd2);
      chk("to_out_valid", 32'(bus.out_valid), 32'd1);
      chk("to_icode_nop", 32'(bus.icode_out), 32'h1);
      tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("to_halted_ready", 32'(bus.in_ready), 32'd0);
      chk("to_halted_out_valid", 32'(bus.out_valid), 32'd0);
      do_reset();

      // ack on the timeout cycle wins
      offer(4'h9, 32'h0, 32'h24, 32'h0);
      for (int i = 0; i < 254; i++) tick();
      chk("race_req_still", 32'(bus.mem_req), 32'd1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1234;
      tick();
      bus.mem_ack   = 1'b0;
      chk("race_stat", 32'(bus.stat), 32'd0);
      chk("race_valM_out", bus.valM_out, 32'h1234);
      chk("race_icode_out", 32'(bus.icode_out), 32'h9);
      tick();

      // invalid icode
      offer(4'hE, 32'h0, 32'h0, 32'h0);
      chk("ins_stat", 32'(bus.stat), 32'd3);
      chk("ins_out_valid", 32'(bus.out_valid), 32'd1);
      tick();
      tick();
      chk("ins_halted_ready", 32'(bus.in_ready), 32'd0);
      do_reset();

      // halt
      offer(4'h0, 32'h0, 32'h0, 32'h0);
      chk("hlt_stat", 32'(bus.stat), 32'd1);
      chk("hlt_icode_out", 32'(bus.icode_out), 32'h0);
      chk("hlt_out_valid", 32'(bus.out_valid), 32'd1);
      tick();
      chk("hlt_icode_nop", 32'(bus.icode_out), 32'h1);
      chk("hlt_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      bus.icode    = 4'h6;
      tick();
      tick();
      bus.in_valid = 1'b0;
      chk("hlt_no_accept", 32'(bus.out_valid), 32'd0);
      chk("hlt_stat_hold", 32'(bus.stat), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Y86 memory stage. Sits between execute and write-back.
- Takes one decoded/executed instruction per handshake and performs its single data-memory access, if any, over a req/ack bus.
- Presents icode, rA, rB, valE and valM to write-back as registered outputs.
- Tracks processor status (AOK/HLT/ADR/INS) and freezes the pipeline on a fault or halt.

Parameters:
- MEM_TIMEOUT, 255, max cycles mem_req may wait for mem_ack before an ADR fault; 8-bit counter.
- ADDR_LIMIT, 32'h0000_FFFF, highest legal byte address of a word access; addr+3 > ADDR_LIMIT gives ADR.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage offers an instruction
- in_ready  out  1  stage accepts an instruction this cycle
- icode  in  4  instruction code 0x0..0xB
- rA  in  4  register A id
- rB  in  4  register B id
- valE  in  32  ALU result
- valA  in  32  register A value
- valP  in  32  next-PC value
- out_valid  out  1  one-cycle pulse: outputs hold a completed instruction
- icode_out  out  4  icode to write-back
- rA_out  out  4  register A to write-back
- rB_out  out  4  register B to write-back
- valE_out  out  32  valE passthrough
- valM_out  out  32  memory read data; 0 for non-reads
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS

Behaviour:
- Reset (async, reset_n=0): state IDLE, in_ready=1, out_valid=0, icode_out=4'h1 (nop), rA_out=rB_out=4'hF, valE_out=valM_out=0, mem_req=mem_we=0, mem_addr=mem_wdata=0, stat=AOK, timeout counter=0.
- Reset asserted mid-access drops mem_req immediately and discards the instruction.
- Acceptance: an instruction is accepted when in_valid && in_ready at a rising edge. in_ready=1 only in IDLE.
- Access decode, by icode:
  - 0x4 rmmovl: write, addr=valE, data=valA.
  - 0x5 mrmovl: read, addr=valE.
  - 0x8 call: write, addr=valE, data=valP.
  - 0x9 ret: read, addr=valA.
  - 0xA pushl: write, addr=valE, data=valA.
  - 0xB popl: read, addr=valA.
  - 0x0–0x3, 0x6, 0x7: no access.
  - 0xC–0xF: invalid.
- States and transitions:
  - IDLE: on accept with no access -> RESP. On accept with access -> ACCESS, with mem_req/mem_we/mem_addr/mem_wdata registered from the decode. On accept of an invalid icode -> RESP with stat=INS.
  - ACCESS: mem_req held at 1, all bus fields stable, until mem_ack. On mem_ack -> RESP; for reads, valM_out <= mem_rdata. mem_req drops the cycle after ack. Counter increments each waiting cycle; if it reaches MEM_TIMEOUT, drop mem_req, stat=ADR, -> RESP.
  - RESP: out_valid=1 for exactly one cycle. Next state is IDLE if stat==AOK, otherwise HALTED.
  - HALTED: in_ready=0, mem_req=0, out_valid=0, icode_out=nop. Left only by reset.
- Fault and halt rules:
  - Address check happens before issue: addr > ADDR_LIMIT-3 gives stat=ADR, no mem_req, -> RESP. Write-back is suppressed by presenting icode_out=nop in RESP.
  - icode 0x0 (halt): stat=HLT, passed to write-back as 0x0, then HALTED.
- Output timing:
  - Outputs are registered. Output fields hold their value except in RESP updates; in all non-RESP cycles icode_out=4'h1 so write-back performs no writes.
  - Latency from accept to out_valid: 1 cycle for no-access; 2 + wait cycles for access (ack the cycle after request gives 2).
- Simultaneous events:
  - mem_ack in the same cycle the timeout is reached: ack wins.
  - mem_ack outside ACCESS is ignored.

Optional Feature:
- MEM_ALIGN_CHECK_EN
- Defined: any access with mem_addr[1:0] != 0 raises stat=ADR before issue, with no mem_req; behaves like an out-of-range fault.
- Undefined: unaligned addresses are issued unchanged; the memory handles them.

Test Plan:
- Accept icode=0x6, valE=5 -> one cycle later out_valid=1, icode_out=6, valE_out=5, valM_out=0, mem_req never 1, stat=AOK.
- Accept mrmovl 0x5 with valE=0x100; memory acks 3 cycles after req with rdata=0xDEADBEEF -> mem_we=0, mem_addr=0x100; valM_out=0xDEADBEEF, out_valid 1 cycle after ack; stat=AOK.
- Accept pushl 0xA with valE=0x1FC, valA=0x42, immediate ack -> mem_we=1, mem_addr=0x1FC, mem_wdata=0x42; out_valid 2 cycles after accept; icode_out=0xA, valE_out=0x1FC.
- Accept rmmovl with valE=0xFFFE -> no mem_req; stat=ADR; icode_out=1 during RESP; in_ready stays 0 afterwards; pulse reset_n low -> stat=AOK, in_ready=1.
- Accept ret 0x9 with valA=0x20, memory never acks -> mem_req high for exactly MEM_TIMEOUT cycles, then stat=ADR, HALTED.
- Accept icode=0xE -> stat=INS and HALTED. Separately, accept halt 0x0 -> stat=HLT, icode_out=0 for one cycle, no further accepts.
